// File: rtl/ram_share_pkg.sv
// Shared types and constants for the two-port RAM sharing controller.
package ram_share_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic SEL_A  = 1'b0;
    localparam logic SEL_B  = 1'b1;
    localparam int   STAT_W = 16;

endpackage

// File: rtl/ram_share_sp_ram.sv
// Standard single-port RAM: synchronous write, registered read (1-cycle latency).
module ram_share_sp_ram #(
    parameter int SIZE   = 16,
    parameter int DEPTH  = 256,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [SIZE-1:0]   wdata_i,
    output logic [SIZE-1:0]   rdata_o
);

    logic [SIZE-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_o <= mem_q[addr_i];
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter; pointer holds the most recently granted port.
module rr_arb2
    import ram_share_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    output logic [1:0] gnt_o
);

    logic ptr_q, ptr_d;

    always_comb begin
        gnt_o = 2'b00;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (ptr_q == SEL_B) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
        ptr_d = ptr_q;
        if (upd_i && (gnt_o != 2'b00)) begin
            ptr_d = gnt_o[1] ? SEL_B : SEL_A;
        end
    end

    // Pointer starts at B so that A wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= SEL_B;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ram_share_ctrl.sv
// Shares one single-port RAM between ports A and B with round-robin arbitration,
// zero-filling the RAM after reset. Optional grant counters: RAM_SHARE_STATS_EN.
module ram_share_ctrl
    import ram_share_pkg::*;
#(
    parameter int SIZE   = 16,
    parameter int DEPTH  = 256,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [SIZE-1:0]   a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [SIZE-1:0]   b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [SIZE-1:0]   rdata,
    output logic              init_done
`ifdef RAM_SHARE_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] a_gnt_cnt,
    output logic [STAT_W-1:0] b_gnt_cnt
`endif
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              run;
    logic [1:0]        gnt;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [SIZE-1:0]   ram_wdata;
    logic              a_rvalid_q, b_rvalid_q;

    assign run       = (state_q == ST_RUN);
    assign init_done = run;
    assign a_gnt     = gnt[0];
    assign b_gnt     = gnt[1];
    assign a_rvalid  = a_rvalid_q;
    assign b_rvalid  = b_rvalid_q;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (run ? {b_req, a_req} : 2'b00),
        .upd_i (run),
        .gnt_o (gnt)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                state_d = ST_RUN;
            end else begin
                cnt_d = cnt_q + ADDR_W'(1);
            end
        end
    end

    // INIT owns the RAM for zero-fill; in RUN the granted port drives it.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = cnt_q;
        ram_wdata = '0;
        if (!run) begin
            ram_we = 1'b1;
        end else if (b_gnt) begin
            ram_we    = b_we;
            ram_addr  = b_addr;
            ram_wdata = b_wdata;
        end else if (a_gnt) begin
            ram_we    = a_we;
            ram_addr  = a_addr;
            ram_wdata = a_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_rvalid_q <= a_gnt & ~a_we;
            b_rvalid_q <= b_gnt & ~b_we;
        end
    end

    ram_share_sp_ram #(
        .SIZE  (SIZE),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (rdata)
    );

`ifdef RAM_SHARE_STATS_EN
    logic [STAT_W-1:0] a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;

    always_comb begin
        a_cnt_d = a_cnt_q;
        b_cnt_d = b_cnt_q;
        if (stat_clr) begin
            a_cnt_d = '0;
            b_cnt_d = '0;
        end else begin
            if (a_gnt && (a_cnt_q != '1)) a_cnt_d = a_cnt_q + STAT_W'(1);
            if (b_gnt && (b_cnt_q != '1)) b_cnt_d = b_cnt_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_cnt_q <= '0;
            b_cnt_q <= '0;
        end else begin
            a_cnt_q <= a_cnt_d;
            b_cnt_q <= b_cnt_d;
        end
    end

    assign a_gnt_cnt = a_cnt_q;
    assign b_gnt_cnt = b_cnt_q;
`endif

endmodule

// File: tb/tb_ram_share_ctrl.sv
// Directed self-checking bench for ram_share_ctrl (DEPTH=16); covers
// RAM_SHARE_STATS_EN when that macro is defined.
module tb_ram_share_ctrl;

    localparam int SIZE   = 16;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              a_req, a_we, b_req, b_we;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [SIZE-1:0]   a_wdata, b_wdata;
    logic              a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [SIZE-1:0]   rdata;
    logic              init_done;
`ifdef RAM_SHARE_STATS_EN
    logic              stat_clr;
    logic [15:0]       a_gnt_cnt, b_gnt_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_share_ctrl #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_gnt     (a_gnt),
        .a_rvalid  (a_rvalid),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_gnt     (b_gnt),
        .b_rvalid  (b_rvalid),
        .rdata     (rdata),
        .init_done (init_done)
`ifdef RAM_SHARE_STATS_EN
        ,
        .stat_clr  (stat_clr),
        .a_gnt_cnt (a_gnt_cnt),
        .b_gnt_cnt (b_gnt_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for init_done with a cycle bound, recording whether any grant leaked out.
    task automatic wait_init(output int cycles, output logic leak);
        cycles = 0;
        leak   = 1'b0;
        while (!init_done && cycles < 40) begin
            if (a_gnt || b_gnt) leak = 1'b1;
            tick();
            cycles++;
        end
    endtask

    initial begin
        int   n;
        logic leak;
        logic [1:0] prev;

        rst_n = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b1; b_we = 1'b0; b_addr = '0; b_wdata = '0;
`ifdef RAM_SHARE_STATS_EN
        stat_clr = 1'b0;
`endif
        tick();
        tick();
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
        check("rst_gnt", 32'({a_gnt, b_gnt}), 32'd0);

        rst_n = 1'b1;
        wait_init(n, leak);
        check("init_cycles", 32'(n), 32'd16);
        check("init_no_gnt", 32'(leak), 32'd0);

        // Both reading: grants alternate A,B,A,B,A,B, rvalid lags by one cycle.
        a_addr = 4'd1;
        b_addr = 4'd2;
        prev   = 2'b00;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("alt_gnt", 32'({b_gnt, a_gnt}), (i % 2 == 0) ? 32'd1 : 32'd2);
            check("alt_rvalid", 32'({b_rvalid, a_rvalid}), 32'(prev));
            prev = {b_gnt, a_gnt};
            tick();
        end
        b_req = 1'b0;
        check("alt_last_rvalid", 32'({b_rvalid, a_rvalid}), 32'd2);
        check("alt_last_rdata", 32'(rdata), 32'd0);

        for (int i = 0; i < DEPTH; i++) begin
            a_addr = ADDR_W'(i);
            tick();
            check("zero_read", 32'({a_rvalid, rdata}), {15'd0, 1'b1, 16'h0000});
        end
        a_req = 1'b0;
        tick();
        check("idle_rvalid", 32'({b_rvalid, a_rvalid}), 32'd0);

        // Write then read-back at address 5.
        a_req = 1'b1; a_we = 1'b1; a_addr = 4'd5; a_wdata = 16'hBEEF;
        #1;
        check("wr_gnt", 32'(a_gnt), 32'd1);
        tick();
        check("wr_no_rvalid", 32'(a_rvalid), 32'd0);
        a_we = 1'b0;
        #1;
        check("rd_gnt", 32'(a_gnt), 32'd1);
        tick();
        a_req = 1'b0;
        check("raw_rvalid", 32'({b_rvalid, a_rvalid}), 32'd1);
        check("raw_rdata", 32'(rdata), 32'h0000BEEF);

        // B alone three times, then both: A wins the tie, then B.
        b_req = 1'b1; b_addr = 4'd5;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("b_only_gnt", 32'({b_gnt, a_gnt}), 32'd2);
            tick();
        end
        check("b_rdata", 32'({b_rvalid, rdata}), {15'd0, 1'b1, 16'hBEEF});
        a_req = 1'b1;
        #1;
        check("tie_a_first", 32'({b_gnt, a_gnt}), 32'd1);
        tick();
        check("tie_a_rvalid", 32'({b_rvalid, a_rvalid}), 32'd1);
        check("tie_b_next", 32'({b_gnt, a_gnt}), 32'd2);
        tick();
        a_req = 1'b0; b_req = 1'b0;
        tick();

        // Reset during an outstanding read: rvalid never appears, RAM re-zeroed.
        a_req = 1'b1; a_addr = 4'd5;
        #1;
        check("mid_rd_gnt", 32'(a_gnt), 32'd1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_rvalid", 32'({b_rvalid, a_rvalid}), 32'd0);
        check("mid_rst_init_done", 32'(init_done), 32'd0);
`ifdef RAM_SHARE_STATS_EN
        check("stat_rst", 32'({a_gnt_cnt, b_gnt_cnt}), 32'd0);
`endif
        a_req = 1'b0;
        rst_n = 1'b1;
        wait_init(n, leak);
        check("reinit_cycles", 32'(n), 32'd16);
        a_req = 1'b1;
        tick();
        a_req = 1'b0;
        check("reinit_rdata5", 32'({a_rvalid, rdata}), {15'd0, 1'b1, 16'h0000});

`ifdef RAM_SHARE_STATS_EN
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        check("stat_pre_clr", 32'({a_gnt_cnt, b_gnt_cnt}), 32'd0);
        a_req = 1'b1;
        repeat (4) tick();
        a_req = 1'b0; b_req = 1'b1;
        repeat (2) tick();
        b_req = 1'b0;
        check("stat_a_cnt", 32'(a_gnt_cnt), 32'd4);
        check("stat_b_cnt", 32'(b_gnt_cnt), 32'd2);
        stat_clr = 1'b1;
        tick();
        check("stat_clr", 32'({a_gnt_cnt, b_gnt_cnt}), 32'd0);
        a_req = 1'b1;
        tick();
        stat_clr = 1'b0;
        check("stat_clr_prio", 32'(a_gnt_cnt), 32'd0);
        tick();
        a_req = 1'b0;
        check("stat_after_clr", 32'(a_gnt_cnt), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_share_ctrl.md
Name: ram_share_ctrl

Overview:
- Shares one single-port, 1-cycle-read-latency RAM between two requesters (port A, port B) using round-robin arbitration.
- After reset, sequences a zero-fill of every RAM entry before accepting requests.
- Instantiates the RAM internally. Sits between CPU-side masters (e.g. instruction fetch and data access) and the storage array.

Parameters:
- SIZE, 16, word width in bits.
- DEPTH, 256, number of entries; ADDR_W = $clog2(DEPTH), DEPTH ≥ 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- a_req  in  1  port A request; held with a_we/a_addr/a_wdata until a_gnt
- a_we  in  1  port A write (1) / read (0)
- a_addr  in  ADDR_W  port A address
- a_wdata  in  SIZE  port A write data
- a_gnt  out  1  port A access issued this cycle
- a_rvalid  out  1  rdata holds port A read result
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid  same as port A, for port B
- rdata  out  SIZE  shared read data
- init_done  out  1  zero-fill complete; requests accepted

Behaviour:
- Reset (async, rst_n=0):
  - state=INIT, fill counter=0, last-grant pointer=B (so A wins the first tie).
  - init_done=0, a_rvalid=b_rvalid=0.
  - a_gnt/b_gnt are 0 while in INIT.
  - rdata is unspecified until the first rvalid.
- State INIT:
  - RAM write_en=1, address=counter, write_data=0.
  - Counter increments once per cycle.
  - When counter==DEPTH-1 is written, next state is RUN and init_done=1 from the next cycle.
  - INIT lasts exactly DEPTH cycles; the counter does not wrap.
- State RUN:
  - Grants are combinational from req and the pointer, in the same cycle as the RAM access.
  - Only A requesting: A granted. Only B requesting: B granted.
  - Both requesting: grant goes to the port not granted last. The pointer updates to the granted port on each grant.
  - No requests: no grant, RAM write_en=0, pointer unchanged.
  - At most one gnt per cycle.
- RAM mux:
  - The granted port's address, wdata and we drive the RAM.
  - write_en = gnt & we.
- Read return:
  - x_rvalid is asserted exactly 1 cycle after x_gnt with x_we=0, for one cycle, with rdata valid.
  - Write grants produce no rvalid.
  - Back-to-back grants give one rvalid per cycle, in grant order.
- Read-after-write, same address, consecutive grants: the read returns the newly written value.
  - The write commits at the gnt cycle edge; the read is issued the following cycle.
  - Read and write in the same cycle is impossible (single grant).
- Requester rules:
  - Fields stay stable while req=1 and gnt=0.
  - Deasserting req before gnt is allowed (the request is withdrawn).
  - The controller does not check these rules.
- Reset mid-operation: an outstanding rvalid is discarded, INIT restarts, and RAM contents are re-zeroed.

Optional Feature:
- Macro: RAM_SHARE_STATS_EN.
- Defined:
  - Adds outputs a_gnt_cnt and b_gnt_cnt (16 bits each, out).
  - Each counts grants to its port in RUN, saturating at 16'hFFFF.
  - Adds input stat_clr (1 bit, in): synchronous clear to 0 that takes priority over an increment in the same cycle.
  - Counters reset to 0 on rst_n.
- Undefined: these ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package ram_share_pkg:
  - State enum {ST_INIT, ST_RUN}.
  - Port-select constants SEL_A=1'b0, SEL_B=1'b1.
  - Stats counter width constant STAT_W=16.
- Sub-module rr_arb2: two-request round-robin arbiter, holding the pointer register. Interface: req[1:0] in, gnt[1:0] out, a pointer-update strobe.
- RAM: the team's standard single-port RAM, instanced with SIZE/DEPTH.

Test Plan:
- Reset with DEPTH=16 → init_done rises exactly 16 cycles after rst_n deasserts. Reads of addresses 0..15 all return 0. No gnt during INIT even with a_req=b_req=1.
- A writes 16'hBEEF to addr 5; next cycle A reads addr 5 → a_gnt on both, a_rvalid one cycle after the read grant with rdata=16'hBEEF, b_rvalid stays 0.
- a_req=b_req=1 (reads) held for 6 cycles after init → grants alternate A,B,A,B,A,B. Each x_rvalid lags its gnt by 1 cycle.
- Only B requests for 3 cycles, then both request → B granted 3 times, then A granted next (pointer=B), then B.
- Assert rst_n=0 the cycle after a read grant → no rvalid is seen. INIT reruns and location 5 reads back 0.
- With RAM_SHARE_STATS_EN, 4 A grants and 2 B grants, then stat_clr → a_gnt_cnt=4, b_gnt_cnt=2, then both 0. A grant coinciding with stat_clr leaves the count at 0.
